data_memory_pipelined: RTL and testbench

Byte-addressable, little-endian data memory with a parametrised size and a fixed, parametrised access latency. It supports byte, halfword and word accesses, with sign or zero extension on loads. It sits in the MEM stage of the CPU and uses a single-outstanding-request handshake, so the pipeline stalls on `ready_o` instead of relying on a combinational read. Out-of-range addresses wrap. Misaligned accesses are reported, not executed.

---
 rtl/data_memory_pipelined_if.sv | 28 ++
 rtl/data_memory_pipelined.sv | 155 +++++++++++++++
 tb/tb_data_memory_pipelined.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pipelined_if.sv
`default_nettype none
// ============================================================================
// data_memory_pipelined_if : request/response bundle for the MEM-stage memory
// Rev 1.0
// ============================================================================
interface data_memory_pipelined_if;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic        misalign_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        input  ready_o, valid_o, rdata_o, misalign_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        output ready_o, valid_o, rdata_o, misalign_o
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_pipelined.sv
`default_nettype none
// ============================================================================
// data_memory_pipelined : little-endian byte memory, fixed-latency handshake
// Rev 1.0
// ============================================================================
module data_memory_pipelined #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    data_memory_pipelined_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [AW-1:0]   ea_q, ea_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            valid_q, valid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            mis_q, mis_d;

    logic [7:0]      mem_q [DEPTH_BYTES];

    logic [AW-1:0]   lane_addr [4];
    logic [7:0]      lane_byte [4];
    logic            misal;
    logic            exec;
    logic [31:0]     load_val;
    logic            unused_addr;

    assign unused_addr = ^bus.addr_i[31:AW];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = ea_q + AW'(k);
            lane_byte[k] = mem_q[lane_addr[k]];
        end
    end

    always_comb begin
        case (size_q)
            2'b00:   misal = 1'b0;
            2'b01:   misal = ea_q[0];
            2'b10:   misal = |ea_q[1:0];
            default: misal = 1'b1;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & lane_byte[0][7]}}, lane_byte[0]};
            2'b01:   load_val = {{16{~uns_q & lane_byte[1][7]}}, lane_byte[1], lane_byte[0]};
            default: load_val = {lane_byte[3], lane_byte[2], lane_byte[1], lane_byte[0]};
        endcase
    end

    assign exec = (state_q == S_BUSY) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        ea_d    = ea_q;
        wdata_d = wdata_q;
        valid_d = 1'b0;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_i) begin
                    state_d = S_BUSY;
                    cnt_d   = CW'(LATENCY - 1);
                    we_d    = bus.we_i;
                    size_d  = bus.size_i;
                    uns_d   = bus.unsigned_i;
                    ea_d    = bus.addr_i[AW-1:0];
                    wdata_d = bus.wdata_i;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    valid_d = 1'b1;
                    mis_d   = misal;
                    if (!we_q && !misal) begin
                        rdata_d = load_val;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            ea_q    <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            ea_q    <= ea_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Storage is not reset; an async reset clears state_q, so a pending store never commits.
    always_ff @(posedge clk_i) begin
        if (exec && we_q && !misal) begin
            mem_q[lane_addr[0]] <= wdata_q[7:0];
            if (size_q != 2'b00) begin
                mem_q[lane_addr[1]] <= wdata_q[15:8];
            end
            if (size_q == 2'b10) begin
                mem_q[lane_addr[2]] <= wdata_q[23:16];
                mem_q[lane_addr[3]] <= wdata_q[31:24];
            end
        end
    end

    assign bus.ready_o    = (state_q == S_IDLE);
    assign bus.valid_o    = valid_q;
    assign bus.rdata_o    = rdata_q;
    assign bus.misalign_o = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_pipelined.sv
`default_nettype none
// ============================================================================
// tb_data_memory_pipelined : random + directed bench against a byte-array model
// Rev 1.0
// ============================================================================
module tb_data_memory_pipelined;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_pipelined_if bus();

    data_memory_pipelined #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    byte unsigned mem_m [DEPTH];
    logic [31:0]  rdata_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain byte-array arithmetic, sign extension by subtracting 2^(8n).
    task automatic model_access(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic mis);
        int     ea;
        int     n;
        longint v;
        logic [31:0] sh;
        ea  = int'(addr % 32'(DEPTH));
        n   = 1 << sz;
        mis = (sz == 2'd3) || ((ea % n) != 0);
        if (mis) return;
        if (we) begin
            for (int k = 0; k < n; k++) begin
                sh = wd >> (8 * k);
                mem_m[(ea + k) % DEPTH] = sh[7:0];
            end
        end else begin
            v = 0;
            for (int k = 0; k < n; k++)
                v = v | (longint'(mem_m[(ea + k) % DEPTH]) << (8 * k));
            if (!uns && n < 4 && ((v >> (8 * n - 1)) & 1) == 1)
                v = v - (longint'(1) << (8 * n));
            rdata_m = v[31:0];
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic mis);
        int          waitc;
        int          lat;
        logic        mis_m;
        logic [31:0] r;
        @(negedge clk);
        waitc = 0;
        while (bus.ready_o !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check_eq("ready_idle", 32'(bus.ready_o), 32'd1);
        bus.req_i      = 1'b1;
        bus.we_i       = we;
        bus.size_i     = sz;
        bus.unsigned_i = uns;
        bus.addr_i     = addr;
        bus.wdata_i    = wd;
        @(posedge clk);
        @(negedge clk);
        r              = $urandom;
        bus.req_i      = 1'b0;
        bus.we_i       = r[0];
        bus.size_i     = r[2:1];
        bus.unsigned_i = r[3];
        bus.addr_i     = $urandom;
        bus.wdata_i    = $urandom;
        check_eq("ready_busy", 32'(bus.ready_o), 32'd0);
        lat = 0;
        while (bus.valid_o !== 1'b1 && lat < LAT + 8) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(LAT));
        model_access(we, sz, uns, addr, wd, mis_m);
        check_eq("misalign", 32'(bus.misalign_o), 32'(mis_m));
        check_eq("rdata", bus.rdata_o, rdata_m);
        rd  = bus.rdata_o;
        mis = bus.misalign_o;
    endtask

    initial begin
        logic [31:0] rd;
        logic        mis;
        logic [31:0] prev;
        logic [31:0] old40;
        logic [31:0] r;
        logic [31:0] a;
        int          accepts;
        int          valids;
        int          last;

        rst            = 1'b1;
        bus.req_i      = 1'b0;
        bus.we_i       = 1'b0;
        bus.size_i     = 2'b00;
        bus.unsigned_i = 1'b0;
        bus.addr_i     = '0;
        bus.wdata_i    = '0;
        rdata_m        = '0;
        #12;
        check_eq("rst_ready", 32'(bus.ready_o), 32'd1);
        check_eq("rst_valid", 32'(bus.valid_o), 32'd0);
        check_eq("rst_misalign", 32'(bus.misalign_o), 32'd0);
        check_eq("rst_rdata", bus.rdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < DEPTH / 4; i++)
            do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, rd, mis);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, mis);
        check_eq("st_word_mis", 32'(mis), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, mis);
        check_eq("word_roundtrip", rd, 32'hDEADBEEF);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, mis);
        check_eq("lb_signed", rd, 32'hFFFFFFDE);
        do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, rd, mis);
        check_eq("lhu", rd, 32'h0000BEEF);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, mis);
        check_eq("lh_signed", rd, 32'hFFFFDEAD);

        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAAAA55, rd, mis);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, mis);
        check_eq("partial_store", rd, 32'hDEAD55EF);

        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, prev, mis);
        do_req(1'b1, 2'd2, 1'b0, 32'h21, 32'hCAFEF00D, rd, mis);
        check_eq("mis_store_flag", 32'(mis), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, mis);
        check_eq("mis_store_nowrite", rd, prev);
        prev = rd;
        do_req(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, rd, mis);
        check_eq("mis_load_flag", 32'(mis), 32'd1);
        check_eq("mis_load_hold", rd, prev);
        do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, rd, mis);
        check_eq("reserved_flag", 32'(mis), 32'd1);

        do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, rd, mis);
        do_req(1'b0, 2'd2, 1'b0, 32'h000, 32'h0, rd, mis);
        check_eq("wrap", rd, 32'h12345678);

        // Held request: one acceptance per BUSY period, ready low for LAT cycles in between.
        @(negedge clk);
        bus.req_i      = 1'b1;
        bus.we_i       = 1'b0;
        bus.size_i     = 2'd2;
        bus.unsigned_i = 1'b0;
        bus.addr_i     = 32'h0;
        accepts = 0;
        valids  = 0;
        last    = -1;
        for (int i = 0; i < 3 * (LAT + 1); i++) begin
            if (i > 0) @(negedge clk);
            if (bus.ready_o === 1'b1) begin
                if (last >= 0) check_eq("accept_gap", 32'(i - last), 32'(LAT + 1));
                last = i;
                accepts++;
            end
            if (bus.valid_o === 1'b1) valids++;
        end
        @(negedge clk);
        bus.req_i = 1'b0;
        check_eq("hold_final_valid", 32'(bus.valid_o), 32'd1);
        check_eq("hold_accepts", 32'(accepts), 32'd3);
        check_eq("hold_valids", 32'(valids), 32'd2);
        check_eq("hold_rdata", bus.rdata_o, 32'h12345678);

        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, old40, mis);
        @(negedge clk);
        bus.req_i      = 1'b1;
        bus.we_i       = 1'b1;
        bus.size_i     = 2'd2;
        bus.unsigned_i = 1'b0;
        bus.addr_i     = 32'h40;
        bus.wdata_i    = ~old40;
        @(posedge clk);
        @(negedge clk);
        bus.req_i = 1'b0;
        check_eq("pre_rst_busy", 32'(bus.ready_o), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_ready", 32'(bus.ready_o), 32'd1);
        check_eq("async_rst_valid", 32'(bus.valid_o), 32'd0);
        check_eq("async_rst_rdata", bus.rdata_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        rdata_m = '0;
        valids  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.valid_o !== 1'b0) valids++;
        end
        check_eq("rst_no_valid", 32'(valids), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, mis);
        check_eq("rst_store_dropped", rd, old40);

        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            a = $urandom;
            if (r[4]) a[1:0] = 2'b00;
            do_req(r[0], r[2:1], r[3], a, $urandom, rd, mis);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
